// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C request arbiter: FSM states, transfer descriptor
// layout and the error encoding used on resp_ack.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_RESP
    } arb_state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       wlen;
        logic [7:0] wdata1;
        logic [7:0] wdata2;
        logic       read;
    } i2c_desc_t;

    // resp_ack value reporting a NACK or an aborted transfer
    localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin selector: starting just after 'last', return the
// first requester found searching upward with wrap, as one-hot and as index.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan offsets 1..N from 'last'; the first active request wins
    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master engine between N_REQ requesters. Grants round-robin,
// latches the winner's descriptor onto the master, runs the START/END
// handshake and returns ACK/read data with a one-cycle done pulse. A
// watchdog aborts stalled transfers so a wedged bus cannot block others.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int START_TMO = 1024,
    parameter int RUN_TMO   = 2_000_000
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_wlen,
    input  logic [8*N_REQ-1:0]   req_wdata1,
    input  logic [8*N_REQ-1:0]   req_wdata2,
    input  logic [N_REQ-1:0]     req_read,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 resp_ack,
    output logic                 resp_tmo,
    output logic [7:0]           resp_rdata,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic                 m_wlen,
    output logic [7:0]           m_wdata1,
    output logic [7:0]           m_wdata2,
    output logic                 m_read,
    input  logic                 m_end,
    input  logic                 m_ack,
    input  logic [7:0]           m_rdata
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(RUN_TMO);
    localparam logic [CW-1:0] START_LIM = CW'(START_TMO - 1);
    localparam logic [CW-1:0] RUN_LIM   = CW'(RUN_TMO - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    arb_state_t      state_reg;
    logic [IW-1:0]   last_reg;
    logic [IW-1:0]   cur_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic            sync_after_reg;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    i2c_desc_t        desc_in [N_REQ];
    i2c_desc_t        pick_desc;

    // Unpack the flat per-requester buses into descriptor records
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_desc
            assign desc_in[gi] = '{addr:   req_addr[7*gi +: 7],
                                   wlen:   req_wlen[gi],
                                   wdata1: req_wdata1[8*gi +: 8],
                                   wdata2: req_wdata2[8*gi +: 8],
                                   read:   req_read[gi]};
        end
    endgenerate

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req  (req),
        .last (last_reg),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // One-hot mux of the winning descriptor (no out-of-range index possible)
    always_comb begin
        pick_desc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_desc = pick_desc | desc_in[i];
            end
        end
    end

    // Watchdog counter increment, saturating instead of wrapping
    always_comb begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg      <= ST_SYNC;
            last_reg       <= IW'(N_REQ - 1);
            cur_reg        <= '0;
            cnt_reg        <= '0;
            sync_after_reg <= 1'b0;
            gnt            <= '0;
            done           <= '0;
            resp_ack       <= 1'b0;
            resp_tmo       <= 1'b0;
            resp_rdata     <= 8'h00;
            m_start        <= 1'b0;
            m_addr         <= 7'h00;
            m_wlen         <= 1'b0;
            m_wdata1       <= 8'h00;
            m_wdata2       <= 8'h00;
            m_read         <= 1'b0;
        end else begin
            done <= '0;
            case (state_reg)
                // Master is not reset with us: wait until it reports idle
                ST_SYNC: begin
                    if (m_end) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick_gnt;
                        cur_reg   <= pick_idx;
                        m_addr    <= pick_desc.addr;
                        m_wlen    <= pick_desc.wlen;
                        m_wdata1  <= pick_desc.wdata1;
                        m_wdata2  <= pick_desc.wdata2;
                        m_read    <= pick_desc.read;
                        m_start   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_LAUNCH;
                    end
                end
                // Hold START until the master acknowledges by dropping END
                ST_LAUNCH: begin
                    if (!m_end) begin
                        m_start   <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end else if (cnt_reg == START_LIM) begin
                        m_start        <= 1'b0;
                        resp_tmo       <= 1'b1;
                        resp_ack       <= RESP_ERR;
                        resp_rdata     <= 8'h00;
                        done           <= gnt;
                        sync_after_reg <= 1'b0;
                        state_reg      <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                // Transfer in progress: END high again means finished
                ST_RUN: begin
                    if (m_end) begin
                        resp_ack       <= m_ack;
                        resp_tmo       <= 1'b0;
                        resp_rdata     <= m_read ? m_rdata : 8'h00;
                        done           <= gnt;
                        sync_after_reg <= 1'b0;
                        state_reg      <= ST_RESP;
                    end else if (cnt_reg == RUN_LIM) begin
                        // Master still busy: resync before trusting it again
                        resp_tmo       <= 1'b1;
                        resp_ack       <= RESP_ERR;
                        resp_rdata     <= 8'h00;
                        done           <= gnt;
                        sync_after_reg <= 1'b1;
                        state_reg      <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                // Done cycle: release grant and advance round-robin pointer
                ST_RESP: begin
                    gnt       <= '0;
                    last_reg  <= cur_reg;
                    state_reg <= sync_after_reg ? ST_SYNC : ST_IDLE;
                end
                default: begin
                    state_reg <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a table of single transfers through a
// behavioural master, then hand-written watchdog and reset sequences.
module tb_i2c_req_arbiter;

    localparam int N = 3;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b1;
    logic [2:0]    req = '0;
    logic [20:0]   req_addr;
    logic [2:0]    req_wlen;
    logic [23:0]   req_wdata1;
    logic [23:0]   req_wdata2;
    logic [2:0]    req_read;
    logic [2:0]    gnt;
    logic [2:0]    done;
    logic          resp_ack;
    logic          resp_tmo;
    logic [7:0]    resp_rdata;
    logic          m_start;
    logic [6:0]    m_addr;
    logic          m_wlen;
    logic [7:0]    m_wdata1;
    logic [7:0]    m_wdata2;
    logic          m_read;
    logic          m_end = 1'b1;
    logic          m_ack = 1'b0;
    logic [7:0]    m_rdata = 8'h00;

    // master model controls: 0 = auto, 1 = END stuck high, 2 = END stuck low
    int            mdl_mode = 0;
    int            mdl_len = 3;
    logic          mdl_ack = 1'b0;
    logic [7:0]    mdl_rdata = 8'h00;
    logic          mbusy = 1'b0;
    int            mcnt = 0;
    logic          m_start_d = 1'b0;
    int            start_cnt = 0;

    int            n_cmp = 0;
    int            n_bad = 0;

    typedef struct {
        logic [2:0] rq;
        int         eg;
        logic       mack;
        logic [7:0] mrd;
        logic       eack;
        logic [7:0] erd;
    } vec_t;

    vec_t vecs [10];

    i2c_req_arbiter #(
        .N_REQ     (N),
        .START_TMO (16),
        .RUN_TMO   (64)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .req        (req),
        .req_addr   (req_addr),
        .req_wlen   (req_wlen),
        .req_wdata1 (req_wdata1),
        .req_wdata2 (req_wdata2),
        .req_read   (req_read),
        .gnt        (gnt),
        .done       (done),
        .resp_ack   (resp_ack),
        .resp_tmo   (resp_tmo),
        .resp_rdata (resp_rdata),
        .m_start    (m_start),
        .m_addr     (m_addr),
        .m_wlen     (m_wlen),
        .m_wdata1   (m_wdata1),
        .m_wdata2   (m_wdata2),
        .m_read     (m_read),
        .m_end      (m_end),
        .m_ack      (m_ack),
        .m_rdata    (m_rdata)
    );

    always #5 iCLK = ~iCLK;

    // Behavioural master, updated on the falling edge
    always @(negedge iCLK) begin
        if (mdl_mode == 1) begin
            m_end <= 1'b1;
            mbusy <= 1'b0;
        end else if (mdl_mode == 2) begin
            m_end <= 1'b0;
            mbusy <= 1'b0;
        end else if (mbusy) begin
            if (mcnt <= 1) begin
                m_end   <= 1'b1;
                m_ack   <= mdl_ack;
                m_rdata <= mdl_rdata;
                mbusy   <= 1'b0;
            end
            mcnt <= mcnt - 1;
        end else if (m_start) begin
            m_end <= 1'b0;
            mbusy <= 1'b1;
            mcnt  <= mdl_len;
        end else begin
            m_end <= 1'b1;
        end
    end

    // Count START rising edges
    always @(posedge iCLK) begin
        m_start_d <= m_start;
        if (m_start && !m_start_d) begin
            start_cnt <= start_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_desc();
        req_addr   = {7'h3F, 7'h50, 7'h39};
        req_wlen   = 3'b001;
        req_wdata1 = {8'h10, 8'h00, 8'h98};
        req_wdata2 = {8'h00, 8'h00, 8'h03};
        req_read   = 3'b010;
    endtask

    function automatic logic [24:0] exp_desc(input int i);
        case (i)
            0:       return {7'h39, 1'b1, 8'h98, 8'h03, 1'b0};
            1:       return {7'h50, 1'b0, 8'h00, 8'h00, 1'b1};
            default: return {7'h3F, 1'b0, 8'h10, 8'h00, 1'b0};
        endcase
    endfunction

    function automatic logic [24:0] act_desc();
        return {m_addr, m_wlen, m_wdata1, m_wdata2, m_read};
    endfunction

    // Wait (bounded) for a done pulse, sampling on falling edges
    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done != 3'b000) break;
            @(negedge iCLK);
        end
        chk({tag, "_done_seen"}, 32'(done != 3'b000), 32'd1);
    endtask

    task automatic wait_gnt(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (gnt != 3'b000) break;
            @(negedge iCLK);
        end
        chk({tag, "_gnt_seen"}, 32'(gnt != 3'b000), 32'd1);
    endtask

    // One complete transfer starting from IDLE; returns at the done cycle with req dropped
    task automatic txn(input string tag, input logic [2:0] rq, input int eg,
                       input logic mack, input logic [7:0] mrd,
                       input logic eack, input logic [7:0] erd);
        int s0;
        logic [2:0] eoh;
        eoh = 3'b001 << eg;
        mdl_ack = mack;
        mdl_rdata = mrd;
        @(negedge iCLK);
        s0 = start_cnt;
        req = rq;
        @(negedge iCLK);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eoh));
        chk({tag, "_m_start"}, 32'(m_start), 32'd1);
        chk({tag, "_desc"}, 32'(act_desc()), 32'(exp_desc(eg)));
        // Inputs after grant must not disturb the transfer in flight
        req = 3'b000;
        req_addr = 21'($urandom);
        req_wdata1 = 24'($urandom);
        req_wdata2 = 24'($urandom);
        req_read = ~req_read;
        wait_done(tag, 200);
        chk({tag, "_done"}, 32'(done), 32'(eoh));
        chk({tag, "_gnt_at_done"}, 32'(gnt), 32'(eoh));
        chk({tag, "_ack"}, 32'(resp_ack), 32'(eack));
        chk({tag, "_tmo"}, 32'(resp_tmo), 32'd0);
        chk({tag, "_rdata"}, 32'(resp_rdata), 32'(erd));
        chk({tag, "_desc_hold"}, 32'(act_desc()), 32'(exp_desc(eg)));
        chk({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
        $display("txn %s: req=%b gnt=%b done=%b ack=%b tmo=%b rdata=%02h",
                 tag, rq, gnt, done, resp_ack, resp_tmo, resp_rdata);
        set_desc();
    endtask

    initial begin
        bit saw;
        vecs[0] = '{3'b001, 0, 1'b0, 8'h55, 1'b0, 8'h00};
        vecs[1] = '{3'b010, 1, 1'b0, 8'hA5, 1'b0, 8'hA5};
        vecs[2] = '{3'b100, 2, 1'b1, 8'h77, 1'b1, 8'h00};
        vecs[3] = '{3'b111, 0, 1'b0, 8'h11, 1'b0, 8'h00};
        vecs[4] = '{3'b111, 1, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[5] = '{3'b111, 2, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{3'b101, 0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[7] = '{3'b101, 2, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[8] = '{3'b011, 0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[9] = '{3'b001, 0, 1'b0, 8'hFF, 1'b0, 8'h00};
        set_desc();

        // Reset values
        #2 iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_desc", 32'(act_desc()), 32'd0);
        chk("rst_resp", 32'({resp_ack, resp_tmo, resp_rdata}), 32'd0);
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);

        // Table of ordinary transfers
        for (int v = 0; v < 10; v++) begin
            txn($sformatf("vec%0d", v), vecs[v].rq, vecs[v].eg, vecs[v].mack,
                vecs[v].mrd, vecs[v].eack, vecs[v].erd);
        end

        // START watchdog: END never drops
        mdl_mode = 1;
        @(negedge iCLK);
        req = 3'b010;
        @(negedge iCLK);
        chk("stmo_gnt", 32'(gnt), 32'b010);
        req = 3'b000;
        repeat (15) @(negedge iCLK);
        chk("stmo_start_held", 32'(m_start), 32'd1);
        chk("stmo_no_early_done", 32'(done), 32'd0);
        @(negedge iCLK);
        chk("stmo_start_low", 32'(m_start), 32'd0);
        chk("stmo_done", 32'(done), 32'b010);
        chk("stmo_flags", 32'({resp_tmo, resp_ack}), 32'b11);
        chk("stmo_rdata", 32'(resp_rdata), 32'd0);
        $display("txn stmo: gnt=%b done=%b ack=%b tmo=%b", gnt, done, resp_ack, resp_tmo);
        mdl_mode = 0;
        txn("after_stmo", 3'b001, 0, 1'b0, 8'h00, 1'b0, 8'h00);

        // RUN watchdog: END stuck low, then SYNC blocks grants until END returns
        @(negedge iCLK);
        req = 3'b100;
        @(negedge iCLK);
        chk("rtmo_gnt", 32'(gnt), 32'b100);
        mdl_mode = 2;
        req = 3'b000;
        wait_done("rtmo", 100);
        chk("rtmo_done", 32'(done), 32'b100);
        chk("rtmo_flags", 32'({resp_tmo, resp_ack}), 32'b11);
        $display("txn rtmo: done=%b ack=%b tmo=%b", done, resp_ack, resp_tmo);
        req = 3'b001;
        saw = 1'b0;
        repeat (10) begin
            @(negedge iCLK);
            if (gnt != 3'b000) saw = 1'b1;
        end
        chk("rtmo_sync_hold", 32'(saw), 32'd0);
        mdl_ack = 1'b1;
        mdl_mode = 0;
        wait_gnt("rtmo_resume", 20);
        chk("rtmo_resume_gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        wait_done("rtmo_resume", 100);
        chk("rtmo_resume_ack", 32'({resp_tmo, resp_ack}), 32'b01);
        $display("txn rtmo_resume: done=%b ack=%b tmo=%b", done, resp_ack, resp_tmo);

        // Reset while the master is mid-transfer
        mdl_len = 20;
        mdl_ack = 1'b0;
        @(negedge iCLK);
        req = 3'b001;
        @(negedge iCLK);
        chk("mrst_gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        repeat (5) @(negedge iCLK);
        mdl_mode = 2;
        iRST_N = 1'b0;
        #1;
        chk("mrst_gnt_clr", 32'(gnt), 32'd0);
        chk("mrst_desc_clr", 32'(act_desc()), 32'd0);
        chk("mrst_resp_clr", 32'({resp_ack, resp_tmo, resp_rdata}), 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        req = 3'b100;
        saw = 1'b0;
        repeat (10) begin
            @(negedge iCLK);
            if (gnt != 3'b000) saw = 1'b1;
        end
        chk("mrst_sync_hold", 32'(saw), 32'd0);
        mdl_len = 3;
        mdl_mode = 0;
        wait_gnt("mrst_resume", 20);
        chk("mrst_resume_gnt", 32'(gnt), 32'b100);
        req = 3'b000;
        wait_done("mrst_resume", 100);
        chk("mrst_resume_done", 32'(done), 32'b100);
        chk("mrst_resume_ack", 32'({resp_tmo, resp_ack}), 32'b00);
        $display("txn mrst_resume: done=%b ack=%b tmo=%b", done, resp_ack, resp_tmo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
